// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back,
// stalls on memReady with an optional abort timeout, and counts retired instructions.
// Optional feature: define MCTRL_BNE_EN to add bne (opcode 000101) through the BRANCH state.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    input  logic             memReady,
    output logic             PcEn,
    output logic [1:0]       PCSrc,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegalOp,
    output logic             memTimeout,
    output logic [CNT_W-1:0] instrCount,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    typedef struct packed {
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem2reg;
        logic       reg_dst;
        logic       reg_wr;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
    } ctl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
`ifdef MCTRL_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    localparam bit             TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam int             TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  WLIM   = TW'(TIMEOUT_CYCLES - 1);

    // Moore outputs as a function of state; registered from the next state so
    // they line up with state_q without a decode stage on the output path.
    function automatic ctl_t ctl_of(input state_e s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_rd = 1'b1; c.src_b = 2'b01; end
            S_DECODE:   c.src_b = 2'b11;
            S_MEMADR:   begin c.src_a = 1'b1; c.src_b = 2'b10; end
            S_MEMREAD:  begin c.mem_rd = 1'b1; c.iord = 1'b1; end
            S_MEMWB:    begin c.reg_wr = 1'b1; c.mem2reg = 1'b1; end
            S_MEMWRITE: begin c.mem_wr = 1'b1; c.iord = 1'b1; end
            S_EXECUTE:  begin c.src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:    begin c.reg_wr = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH:   begin c.src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; end
            S_ADDIEX:   begin c.src_a = 1'b1; c.src_b = 2'b10; end
            S_ADDIWB:   c.reg_wr = 1'b1;
            S_JUMP:     c.pc_src = 2'b10;
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_e            state_q, state_d;
    ctl_t              ctl_q;
    logic [TW-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_sw_q;
    logic              illegal, retire, wait_st, tmo, br_take;

`ifdef MCTRL_BNE_EN
    logic              is_bne_q;
    assign br_take = is_bne_q ? ~Zero : Zero;
`else
    assign br_take = Zero;
`endif

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    // The miss that brings the count to the limit aborts; a ready in that cycle completes instead.
    assign tmo     = TMO_EN && wait_st && !memReady && (wait_q == WLIM);

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MCTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = is_sw_q ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (memReady)  state_d = S_MEMWB;
                else if (tmo)  state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                if (memReady) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (tmo) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEX:   state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:    state_d = S_FETCH;
        endcase
    end

    // Counter runs only while sitting in the same wait state; any entry or abort clears it.
    always_comb begin
        wait_d = '0;
        if (TMO_EN && wait_st && !memReady && !tmo && (state_d == state_q))
            wait_d = wait_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            ctl_q    <= ctl_of(S_FETCH);
            wait_q   <= '0;
            cnt_q    <= '0;
            is_sw_q  <= 1'b0;
`ifdef MCTRL_BNE_EN
            is_bne_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_of(state_d);
            wait_q  <= wait_d;
            if (retire)
                cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == S_DECODE) begin
                is_sw_q  <= (Opcode == OP_SW);
`ifdef MCTRL_BNE_EN
                is_bne_q <= (Opcode == OP_BNE);
`endif
            end
        end
    end

    // Handshake-dependent strobes stay combinational but are forced low during reset.
    assign PcEn       = rst_n && (((state_q == S_FETCH) && memReady) ||
                                  ((state_q == S_BRANCH) && br_take) ||
                                   (state_q == S_JUMP));
    assign IRWrite    = rst_n && (state_q == S_FETCH) && memReady;
    assign illegalOp  = rst_n && (state_q == S_DECODE) && illegal;
    assign memTimeout = rst_n && tmo;

    assign PCSrc      = ctl_q.pc_src;
    assign IorD       = ctl_q.iord;
    assign MemRead    = ctl_q.mem_rd;
    assign MemWrite   = ctl_q.mem_wr;
    assign MemtoReg   = ctl_q.mem2reg;
    assign RegDst     = ctl_q.reg_dst;
    assign RegWrite   = ctl_q.reg_wr;
    assign ALUSrcA    = ctl_q.src_a;
    assign ALUSrcB    = ctl_q.src_b;
    assign ALUOp      = ctl_q.alu_op;
    assign instrCount = cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a default instance plus one with a short
// memory timeout, both driven from the same stimulus.
module tb_mips_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, Zero, memReady;
    logic [5:0]  Opcode;

    logic        PcEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic        illegalOp, memTimeout;
    logic [1:0]  PCSrc, ALUSrcB, ALUOp;
    logic [31:0] instrCount;
    logic [3:0]  state;

    logic        t_PcEn, t_IorD, t_MemRead, t_MemWrite, t_IRWrite, t_MemtoReg, t_RegDst;
    logic        t_RegWrite, t_ALUSrcA, t_illegalOp, t_memTimeout;
    logic [1:0]  t_PCSrc, t_ALUSrcB, t_ALUOp;
    logic [31:0] t_instrCount;
    logic [3:0]  t_state;

    int n_vec = 0;
    int n_err = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .memReady(memReady),
        .PcEn(PcEn), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegalOp(illegalOp),
        .memTimeout(memTimeout), .instrCount(instrCount), .state(state)
    );

    mips_multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .memReady(memReady),
        .PcEn(t_PcEn), .PCSrc(t_PCSrc), .IorD(t_IorD), .MemRead(t_MemRead),
        .MemWrite(t_MemWrite), .IRWrite(t_IRWrite), .MemtoReg(t_MemtoReg),
        .RegDst(t_RegDst), .RegWrite(t_RegWrite), .ALUSrcA(t_ALUSrcA),
        .ALUSrcB(t_ALUSrcB), .ALUOp(t_ALUOp), .illegalOp(t_illegalOp),
        .memTimeout(t_memTimeout), .instrCount(t_instrCount), .state(t_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; memReady = 1'b1; Opcode = 6'b0; Zero = 1'b0;
        repeat (3) tick;
        chk("rst_state", 32'(state), 0);
        chk("rst_pcen",  32'(PcEn), 0);
        chk("rst_irw",   32'(IRWrite), 0);
        chk("rst_memrd", 32'(MemRead), 1);
        chk("rst_srcb",  32'(ALUSrcB), 1);
        chk("rst_cnt",   instrCount, 0);

        // lw, zero wait: 0,1,2,3,4
        rst_n = 1'b1; Opcode = 6'b100011; #1;
        chk("f_irw",  32'(IRWrite), 1);
        chk("f_pcen", 32'(PcEn), 1);
        tick; chk("lw_dec", 32'(state), 1); chk("dec_pcen", 32'(PcEn), 0); chk("dec_srcb", 32'(ALUSrcB), 3);
        tick; chk("lw_adr", 32'(state), 2); chk("adr_srca", 32'(ALUSrcA), 1); chk("adr_srcb", 32'(ALUSrcB), 2);
        tick; chk("lw_rd",  32'(state), 3); chk("rd_iord", 32'(IorD), 1); chk("rd_memrd", 32'(MemRead), 1);
        tick; chk("lw_wb",  32'(state), 4); chk("wb_regw", 32'(RegWrite), 1); chk("wb_m2r", 32'(MemtoReg), 1);
        chk("wb_regdst", 32'(RegDst), 0);
        tick; chk("lw_done", 32'(state), 0); chk("lw_cnt", instrCount, 1);

        // sw
        Opcode = 6'b101011;
        tick; tick; tick;
        chk("sw_st", 32'(state), 5); chk("sw_memw", 32'(MemWrite), 1); chk("sw_memrd", 32'(MemRead), 0);
        tick; chk("sw_done", 32'(state), 0); chk("sw_cnt", instrCount, 2);

        // R-type
        Opcode = 6'b000000;
        tick; tick; chk("r_ex", 32'(state), 6); chk("r_aluop", 32'(ALUOp), 2); chk("r_srcb", 32'(ALUSrcB), 0);
        tick; chk("r_wb", 32'(state), 7); chk("r_regdst", 32'(RegDst), 1); chk("r_regw", 32'(RegWrite), 1);
        tick; chk("r_cnt", instrCount, 3);

        // addi
        Opcode = 6'b001000;
        tick; tick; chk("addi_ex", 32'(state), 9); chk("addi_srcb", 32'(ALUSrcB), 2);
        tick; chk("addi_wb", 32'(state), 10); chk("addi_regw", 32'(RegWrite), 1); chk("addi_m2r", 32'(MemtoReg), 0);
        tick; chk("addi_cnt", instrCount, 4);

        // beq taken / not taken, then j
        Opcode = 6'b000100; Zero = 1'b1;
        tick; tick; chk("beq_st", 32'(state), 8); chk("beq_pcen", 32'(PcEn), 1);
        chk("beq_pcsrc", 32'(PCSrc), 1); chk("beq_aluop", 32'(ALUOp), 1);
        tick; chk("beq_done", 32'(state), 0); chk("beq_cnt", instrCount, 5);
        Zero = 1'b0;
        tick; tick; chk("beqnt_pcen", 32'(PcEn), 0);
        tick; chk("beqnt_done", 32'(state), 0); chk("beqnt_cnt", instrCount, 6);
        Opcode = 6'b000010;
        tick; tick; chk("j_st", 32'(state), 11); chk("j_pcsrc", 32'(PCSrc), 2); chk("j_pcen", 32'(PcEn), 1);
        tick; chk("j_cnt", instrCount, 7);

        // lw with 5-cycle stall in MEMREAD
        Opcode = 6'b100011;
        tick; tick; tick;
        memReady = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_st", 32'(state), 3);
            chk("stall_memrd", 32'(MemRead), 1);
            chk("stall_iord", 32'(IorD), 1);
            chk("stall_tmo", 32'(memTimeout), 0);
            tick;
        end
        memReady = 1'b1; #1;
        chk("stall_last", 32'(state), 3);
        tick; chk("stall_wb", 32'(state), 4);
        tick; chk("stall_cnt", instrCount, 8);

        // Timeout in FETCH on the 4-cycle instance
        rst_n = 1'b0; memReady = 1'b0;
        tick;
        rst_n = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_pulse", 32'(t_memTimeout), (i == 3) ? 32'd1 : 32'd0);
            chk("to_pcen", 32'(t_PcEn), 0);
            chk("to_state", 32'(t_state), 0);
            chk("to_dflt", 32'(memTimeout), 0);
            tick;
        end
        chk("to_after", 32'(t_memTimeout), 0);
        chk("to_state2", 32'(t_state), 0);
        chk("to_cnt", t_instrCount, 0);

        // Ready on the limit cycle: completion wins
        for (int i = 0; i < 3; i++) begin
            chk("lim_pre", 32'(t_memTimeout), 0);
            tick;
        end
        memReady = 1'b1; Opcode = 6'b111111; #1;
        chk("lim_tmo", 32'(t_memTimeout), 0);
        chk("lim_irw", 32'(t_IRWrite), 1);

        // Illegal opcode
        tick;
        chk("ill_st", 32'(state), 1); chk("ill_pulse", 32'(illegalOp), 1);
        tick;
        chk("ill_fetch", 32'(state), 0); chk("ill_clr", 32'(illegalOp), 0); chk("ill_cnt", instrCount, 0);

        // bne with Zero=0
        Opcode = 6'b000101; Zero = 1'b0;
        tick;
`ifdef MCTRL_BNE_EN
        chk("bne_ill", 32'(illegalOp), 0);
        tick; chk("bne_st", 32'(state), 8); chk("bne_pcen", 32'(PcEn), 1);
        tick; chk("bne_cnt", instrCount, 1);
`else
        chk("bne_ill", 32'(illegalOp), 1);
        tick; chk("bne_fetch", 32'(state), 0); chk("bne_cnt", instrCount, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
